// File: rtl/lfsr_period_checker_pkg.sv
// Shared types and constants for the LFSR period checker.
package lfsr_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      ZERO    = 2'd2
   } state_t;

   // Length of a maximal sequence for a w-bit LFSR.
   function automatic int unsigned maxlen(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/lfsr_period_checker_if.sv
// Monitor-side bundle between the LFSR stage and the period checker.
interface lfsr_period_checker_if #(
   parameter int WIDTH = lfsr_pkg::DEFAULT_WIDTH,
   parameter int PW    = WIDTH + 1
);
   import lfsr_pkg::*;

   // valid_in qualifies q_in; there is no ready because the checker never stalls
   // and takes every valid word on the clock edge where valid_in is high.
   logic [WIDTH-1:0] q_in;
   logic             valid_in;
   logic [PW-1:0]    period;
   logic             period_valid;
   logic             max_len;
   logic             stuck_zero;
   logic             seq_err;
   logic             dup_err;
   logic [PW-1:0]    sample_cnt;
   state_t           dbg_state;

   modport master (
      output q_in, valid_in,
      input  period, period_valid, max_len, stuck_zero,
      input  seq_err, dup_err, sample_cnt, dbg_state
   );

   modport slave (
      input  q_in, valid_in,
      output period, period_valid, max_len, stuck_zero,
      output seq_err, dup_err, sample_cnt, dbg_state
   );

endinterface

// File: rtl/lfsr_onehot_dec.sv
// Binary-to-one-hot decoder used to address the seen-state bitmap.
module lfsr_onehot_dec #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]        idx,
   output logic [(1<<WIDTH)-1:0]   onehot
);

   always_comb begin
      onehot      = '0;
      onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/lfsr_period_checker.sv
// Learns a seed from the LFSR stream, measures its recurrence period and flags
// lock-up, duplicate states and period changes.
module lfsr_period_checker
   import lfsr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int PW    = WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   lfsr_period_checker_if.slave mon
);

   localparam int NS = 1 << WIDTH;
   localparam logic [PW-1:0] MAX_CNT = PW'(maxlen(WIDTH));
   localparam logic [PW-1:0] ONE     = PW'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [PW-1:0]    prev_q, prev_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    period_q, period_d;
   logic             have_prev_q, have_prev_d;
   logic             pv_q, pv_d;
   logic             max_q, max_d;
   logic             seq_q, seq_d;
   logic             dup_q, dup_d;
   logic [NS-1:0]    seen_q, seen_d;
   logic [NS-1:0]    q_onehot;
   logic             q_zero, seed_hit, dup_hit;

   lfsr_onehot_dec #(.WIDTH(WIDTH)) u_dec (
      .idx    (mon.q_in),
      .onehot (q_onehot)
   );

   assign q_zero   = (mon.q_in == '0);
   assign seed_hit = (mon.q_in == seed_q);
   assign dup_hit  = |(seen_q & q_onehot);

   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      prev_d      = prev_q;
      cnt_d       = cnt_q;
      period_d    = period_q;
      have_prev_d = have_prev_q;
      pv_d        = 1'b0;
      max_d       = max_q;
      seq_d       = seq_q;
      dup_d       = dup_q;
      seen_d      = seen_q;

      if (mon.valid_in) begin
         unique case (state_q)
            IDLE, ZERO: begin
               if (q_zero) begin
                  state_d = ZERO;
               end else begin
                  seed_d  = mon.q_in;
                  cnt_d   = ONE;
                  seen_d  = q_onehot;
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               // Seed match outranks zero and duplicate checks; the seed bit is in seen.
               if (seed_hit) begin
                  period_d    = cnt_q;
                  pv_d        = 1'b1;
                  max_d       = (cnt_q == MAX_CNT);
                  if (have_prev_q && (cnt_q != prev_q)) seq_d = 1'b1;
                  prev_d      = cnt_q;
                  have_prev_d = 1'b1;
                  cnt_d       = ONE;
                  seen_d      = q_onehot;
               end else if (q_zero) begin
                  state_d     = ZERO;
                  have_prev_d = 1'b0;
               end else if (dup_hit) begin
                  dup_d       = 1'b1;
                  seed_d      = mon.q_in;
                  cnt_d       = ONE;
                  seen_d      = q_onehot;
                  have_prev_d = 1'b0;
               end else begin
                  seen_d = seen_q | q_onehot;
                  cnt_d  = cnt_q + ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         seed_q      <= '0;
         prev_q      <= '0;
         cnt_q       <= '0;
         period_q    <= '0;
         have_prev_q <= 1'b0;
         pv_q        <= 1'b0;
         max_q       <= 1'b0;
         seq_q       <= 1'b0;
         dup_q       <= 1'b0;
         seen_q      <= '0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         prev_q      <= prev_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         have_prev_q <= have_prev_d;
         pv_q        <= pv_d;
         max_q       <= max_d;
         seq_q       <= seq_d;
         dup_q       <= dup_d;
         seen_q      <= seen_d;
      end
   end

   // The state register already gives the one-cycle-after-entry timing for stuck_zero.
   assign mon.period       = period_q;
   assign mon.period_valid = pv_q;
   assign mon.max_len      = max_q;
   assign mon.stuck_zero   = (state_q == ZERO);
   assign mon.seq_err      = seq_q;
   assign mon.dup_err      = dup_q;
   assign mon.sample_cnt   = cnt_q;
   assign mon.dbg_state    = state_q;

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed and random stimulus for lfsr_period_checker against a history-queue model.
module tb_lfsr_period_checker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lfsr_period_checker_if #(.WIDTH(4), .PW(5)) bus ();

   lfsr_period_checker #(.WIDTH(4), .PW(5)) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus)
   );

   // Reference model: remembers the states seen since the seed as a plain list.
   int          m_mode;   // 0 idle, 1 measuring, 2 all-zero lock
   int          m_seed;
   int          m_hist[$];
   int          m_prev;
   bit          m_have_prev;
   int          m_period;
   bit          m_pv, m_max, m_seq, m_dup;

   function automatic void model_reset();
      m_mode = 0; m_seed = 0; m_hist = {}; m_prev = 0; m_have_prev = 0;
      m_period = 0; m_pv = 0; m_max = 0; m_seq = 0; m_dup = 0;
   endfunction

   function automatic bit in_hist(int q);
      foreach (m_hist[i]) if (m_hist[i] == q) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_step(int q, bit v);
      m_pv = 0;
      if (!v) return;
      if (m_mode != 1) begin
         if (q == 0) m_mode = 2;
         else begin m_seed = q; m_hist = {q}; m_mode = 1; end
      end else if (q == m_seed) begin
         m_period = m_hist.size();
         m_pv     = 1;
         m_max    = (m_period == 15);
         if (m_have_prev && m_period != m_prev) m_seq = 1;
         m_prev = m_period; m_have_prev = 1; m_hist = {q};
      end else if (q == 0) begin
         m_mode = 2; m_have_prev = 0;
      end else if (in_hist(q)) begin
         m_dup = 1; m_seed = q; m_hist = {q}; m_have_prev = 0;
      end else begin
         m_hist.push_back(q);
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("period",       32'(bus.period),       32'(m_period));
      check("period_valid", 32'(bus.period_valid), 32'(m_pv));
      check("max_len",      32'(bus.max_len),      32'(m_max));
      check("stuck_zero",   32'(bus.stuck_zero),   32'(m_mode == 2));
      check("seq_err",      32'(bus.seq_err),      32'(m_seq));
      check("dup_err",      32'(bus.dup_err),      32'(m_dup));
      check("sample_cnt",   32'(bus.sample_cnt),   32'(m_hist.size()));
   endtask

   task automatic step(input logic [3:0] q, input logic v);
      @(negedge clk);
      bus.q_in = q; bus.valid_in = v;
      @(posedge clk);
      model_step(int'(q), v);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; bus.valid_in = 1'b1; bus.q_in = 4'($urandom_range(1, 15));
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b1; bus.valid_in = 1'b0;
   endtask

   function automatic logic [3:0] lfsr_next(logic [3:0] s);
      return {s[2:0], s[3] ^ s[2]};
   endfunction

   logic [3:0] s;

   initial begin
      bus.q_in = '0; bus.valid_in = 1'b0;
      model_reset();

      // Maximal x^4+x^3+1 sequence, two full periods plus the closing seed.
      do_reset();
      s = 4'b1000;
      for (int i = 1; i <= 31; i++) begin
         step(s, 1'b1);
         if (i == 16) begin
            check("max_period", 32'(bus.period), 32'd15);
            check("max_pv",     32'(bus.period_valid), 32'd1);
            check("max_flag",   32'(bus.max_len), 32'd1);
         end
         s = lfsr_next(s);
      end
      check("max_pv2",  32'(bus.period_valid), 32'd1);
      check("max_seq0", 32'(bus.seq_err), 32'd0);

      // Two-state loop.
      do_reset();
      for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
      check("short_period", 32'(bus.period), 32'd2);
      check("short_max",    32'(bus.max_len), 32'd0);

      // Period change A B A B C A, then sticky seq_err through more loops.
      do_reset();
      step(4'b0011, 1'b1); step(4'b0110, 1'b1); step(4'b0011, 1'b1);
      check("chg_first", 32'(bus.period), 32'd2);
      step(4'b0110, 1'b1); step(4'b1100, 1'b1); step(4'b0011, 1'b1);
      check("chg_period", 32'(bus.period), 32'd3);
      check("chg_seq",    32'(bus.seq_err), 32'd1);
      for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0110 : 4'b0011, 1'b1);
      check("chg_sticky", 32'(bus.seq_err), 32'd1);

      // Duplicate non-seed state reseeds on 0010.
      do_reset();
      step(4'b0001, 1'b1); step(4'b0010, 1'b1); step(4'b0100, 1'b1); step(4'b0010, 1'b1);
      check("dup_flag", 32'(bus.dup_err), 32'd1);
      check("dup_cnt",  32'(bus.sample_cnt), 32'd1);
      check("dup_pv",   32'(bus.period_valid), 32'd0);
      step(4'b0100, 1'b1); step(4'b0010, 1'b1);
      check("dup_newseed", 32'(bus.period), 32'd2);

      // All-zero lock from IDLE and from MEASURE.
      do_reset();
      step(4'b0000, 1'b1);
      check("zero_idle", 32'(bus.stuck_zero), 32'd1);
      step(4'b0111, 1'b1);
      check("zero_exit", 32'(bus.stuck_zero), 32'd0);
      check("zero_cnt",  32'(bus.sample_cnt), 32'd1);
      step(4'b1000, 1'b1); step(4'b0000, 1'b1);
      check("zero_meas", 32'(bus.stuck_zero), 32'd1);
      step(4'b0111, 1'b1);
      check("zero_cnt2", 32'(bus.sample_cnt), 32'd1);

      // Maximal run with random bubbles.
      do_reset();
      s = 4'b1000;
      for (int i = 0; i < 16; i++) begin
         while ($urandom_range(0, 2) == 0) step(4'($urandom_range(0, 15)), 1'b0);
         step(s, 1'b1);
         s = lfsr_next(s);
      end
      check("bubble_period", 32'(bus.period), 32'd15);

      // Reset after 7 samples; next valid sample is the new seed.
      s = 4'b1000;
      for (int i = 0; i < 7; i++) begin step(s, 1'b1); s = lfsr_next(s); end
      do_reset();
      check("rst_cnt",    32'(bus.sample_cnt), 32'd0);
      check("rst_period", 32'(bus.period), 32'd0);
      step(4'b0101, 1'b1);
      check("rst_seed_cnt", 32'(bus.sample_cnt), 32'd1);
      step(4'b0101, 1'b1);
      check("rst_seed_per", 32'(bus.period), 32'd1);

      // Random small-alphabet stream so seeds, duplicates and zeros all recur.
      do_reset();
      for (int i = 0; i < 400; i++)
         step(4'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
